// File: rtl/fm_hop_scheduler.sv
// Wishbone master that steps the FM generator carrier through a programmable hop table,
// writing one increment word per hop and dwelling a programmed number of clocks between hops.
module fm_hop_scheduler #(
    parameter int         TBL_AW       = 4,
    parameter int         DWELL_W      = 24,
    parameter logic [1:0] HOP_REG_ADDR = 2'd0,
    parameter int         ACK_TIMEOUT  = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop,
    input  logic [TBL_AW:0]     i_num_entries,
    input  logic [DWELL_W-1:0]  i_dwell,
    input  logic                i_tbl_we,
    input  logic [TBL_AW-1:0]   i_tbl_addr,
    input  logic [31:0]         i_tbl_data,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    output logic                o_wb_we,
    output logic [1:0]          o_wb_addr,
    output logic [31:0]         o_wb_data,
    input  logic                i_wb_ack,
    input  logic                i_wb_stall,
    output logic                o_busy,
    output logic                o_hop_strobe,
    output logic [TBL_AW-1:0]   o_hop_index,
    output logic                o_err
);

    localparam int NUM_W     = TBL_AW + 1;
    localparam int TBL_DEPTH = 1 << TBL_AW;
    localparam int TMO_W     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_DWELL
    } state_t;

    state_t              state_q, state_d;
    logic [TBL_AW-1:0]   index_q, index_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic                loop_q, loop_d;
    logic [DWELL_W-1:0]  dwell_len_q, dwell_len_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                stop_pend_q, stop_pend_d;
    logic                err_q, err_d;
    logic                hop_strobe_q, hop_strobe_d;
    logic [31:0]         data_q;

    logic [31:0]         mem [0:TBL_DEPTH-1];

    logic                num_ok;
    logic                last_entry;
    logic                bus_done;

    assign num_ok     = (i_num_entries != '0) && (i_num_entries <= NUM_W'(TBL_DEPTH));
    assign last_entry = ({1'b0, index_q} == (num_q - NUM_W'(1)));

    // Hop table: written any time, read only while loading so the bus word stays put
    // for the whole transaction even if the host rewrites the entry.
    always_ff @(posedge i_clk) begin
        if (i_tbl_we) begin
            mem[i_tbl_addr] <= i_tbl_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
        end else if (state_q == ST_LOAD) begin
            data_q <= mem[index_q];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            num_q        <= '0;
            loop_q       <= 1'b0;
            dwell_len_q  <= '0;
            dwell_cnt_q  <= '0;
            tmo_q        <= '0;
            stop_pend_q  <= 1'b0;
            err_q        <= 1'b0;
            hop_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            num_q        <= num_d;
            loop_q       <= loop_d;
            dwell_len_q  <= dwell_len_d;
            dwell_cnt_q  <= dwell_cnt_d;
            tmo_q        <= tmo_d;
            stop_pend_q  <= stop_pend_d;
            err_q        <= err_d;
            hop_strobe_q <= hop_strobe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        num_d        = num_q;
        loop_d       = loop_q;
        dwell_len_d  = dwell_len_q;
        dwell_cnt_d  = dwell_cnt_q;
        tmo_d        = tmo_q;
        stop_pend_d  = stop_pend_q;
        err_d        = err_q;
        hop_strobe_d = 1'b0;
        bus_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop && num_ok) begin
                    num_d       = i_num_entries;
                    loop_d      = i_loop;
                    dwell_len_d = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
                    index_d     = '0;
                    err_d       = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = i_stop ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (!i_wb_stall) begin
                    tmo_d = '0;
                    if (i_wb_ack) begin
                        bus_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (i_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (i_wb_ack) begin
                    bus_done = 1'b1;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DWELL: begin
                if (i_stop) begin
                    state_d = ST_IDLE;
                end else if (dwell_cnt_q <= DWELL_W'(1)) begin
                    if (!last_entry) begin
                        index_d = index_q + TBL_AW'(1);
                        state_d = ST_LOAD;
                    end else if (loop_q) begin
                        index_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stop seen during the bus transaction ends the sequence once the write lands.
        if (bus_done) begin
            hop_strobe_d = 1'b1;
            if (stop_pend_q || i_stop) begin
                state_d = ST_IDLE;
            end else begin
                dwell_cnt_d = dwell_len_q;
                state_d     = ST_DWELL;
            end
        end
    end

    always_comb begin
        o_wb_cyc = 1'b0;
        o_wb_stb = 1'b0;
        case (state_q)
            ST_WRITE: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
            end
            ST_WAIT_ACK: begin
                o_wb_cyc = 1'b1;
            end
            default: begin
            end
        endcase
        o_wb_we      = o_wb_stb;
        o_wb_addr    = HOP_REG_ADDR;
        o_wb_data    = data_q;
        o_busy       = (state_q != ST_IDLE);
        o_hop_strobe = hop_strobe_q;
        o_hop_index  = index_q;
        o_err        = err_q;
    end

endmodule

// File: tb/tb_fm_hop_scheduler.sv
// Directed bench for fm_hop_scheduler: table-driven hop sequences plus hand-written
// sequences for stall, ack timeout, reset, stop-during-write and table read collisions.
module tb_fm_hop_scheduler;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic        i_stop;
    logic        i_loop;
    logic [4:0]  i_num_entries;
    logic [23:0] i_dwell;
    logic        i_tbl_we;
    logic [3:0]  i_tbl_addr;
    logic [31:0] i_tbl_data;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [1:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic        o_busy;
    logic        o_hop_strobe;
    logic [3:0]  o_hop_index;
    logic        o_err;

    fm_hop_scheduler dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_loop        (i_loop),
        .i_num_entries (i_num_entries),
        .i_dwell       (i_dwell),
        .i_tbl_we      (i_tbl_we),
        .i_tbl_addr    (i_tbl_addr),
        .i_tbl_data    (i_tbl_data),
        .o_wb_cyc      (o_wb_cyc),
        .o_wb_stb      (o_wb_stb),
        .o_wb_we       (o_wb_we),
        .o_wb_addr     (o_wb_addr),
        .o_wb_data     (o_wb_data),
        .i_wb_ack      (i_wb_ack),
        .i_wb_stall    (i_wb_stall),
        .o_busy        (o_busy),
        .o_hop_strobe  (o_hop_strobe),
        .o_hop_index   (o_hop_index),
        .o_err         (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        int num;
        int dwell;
        bit loop;
        int stop_at;     // stop pulsed in the dwell after this many strobes (0 = never)
        int exp_writes;
        int exp_gap;     // clocks between hop strobes
    } row_t;

    row_t        rows [6];
    logic [31:0] tbl [16];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          viol    = 0;
    bit          ack_en  = 1'b1;
    bit          mon_en  = 1'b0;

    // Slave: acks one clock after an accepted strobe, unless acks are disabled.
    always @(posedge i_clk) begin
        if (i_reset) i_wb_ack <= 1'b0;
        else         i_wb_ack <= ack_en && o_wb_cyc && o_wb_stb && !i_wb_stall;
    end

    always @(negedge i_clk) begin
        if (mon_en && ((o_wb_stb && !o_wb_cyc) || (o_wb_we !== o_wb_stb))) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic run_row(input int ri, input row_t r);
        int cyc_n, nw, ns, first_stb, last_strobe, stop_cyc, end_cyc, exp_end;
        cyc_n = 0; nw = 0; ns = 0;
        first_stb = -1; last_strobe = -1; stop_cyc = -1; end_cyc = -1;
        i_num_entries = 5'(r.num);
        i_dwell       = 24'(r.dwell);
        i_loop        = r.loop;
        i_start       = 1'b1;
        while (cyc_n < 2000) begin
            tick;
            cyc_n++;
            i_start = 1'b0;
            i_stop  = 1'b0;
            if (o_wb_stb && first_stb < 0) first_stb = cyc_n;
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                check($sformatf("row%0d write%0d data", ri, nw), o_wb_data, tbl[nw % r.num]);
                check($sformatf("row%0d write%0d addr", ri, nw), 32'(o_wb_addr), 32'd0);
                nw++;
            end
            if (o_hop_strobe) begin
                check($sformatf("row%0d strobe%0d index", ri, ns), 32'(o_hop_index), 32'(ns % r.num));
                if (last_strobe >= 0)
                    check($sformatf("row%0d strobe%0d gap", ri, ns), 32'(cyc_n - last_strobe), 32'(r.exp_gap));
                last_strobe = cyc_n;
                ns++;
                if (r.stop_at != 0 && ns == r.stop_at) begin
                    i_stop   = 1'b1;
                    stop_cyc = cyc_n;
                end
            end
            if (!o_busy) begin
                end_cyc = cyc_n;
                break;
            end
        end
        i_stop = 1'b0;
        exp_end = (stop_cyc >= 0) ? stop_cyc + 1 : last_strobe + (r.exp_gap - 3);
        check($sformatf("row%0d finished", ri), 32'(end_cyc >= 0), 32'd1);
        check($sformatf("row%0d start-to-stb latency", ri), 32'(first_stb), 32'd2);
        check($sformatf("row%0d write count", ri), 32'(nw), 32'(r.exp_writes));
        check($sformatf("row%0d strobe count", ri), 32'(ns), 32'(r.exp_writes));
        check($sformatf("row%0d busy-fall cycle", ri), 32'(end_cyc), 32'(exp_end));
        check($sformatf("row%0d err", ri), 32'(o_err), 32'd0);
        repeat (3) tick;
    endtask

    initial begin
        int n, stb_n, acks, wait_n;
        bit unstable, active;

        rows[0] = '{num: 3,  dwell: 5, loop: 1'b0, stop_at: 0, exp_writes: 3,  exp_gap: 8};
        rows[1] = '{num: 3,  dwell: 5, loop: 1'b1, stop_at: 5, exp_writes: 5,  exp_gap: 8};
        rows[2] = '{num: 1,  dwell: 0, loop: 1'b0, stop_at: 0, exp_writes: 1,  exp_gap: 4};
        rows[3] = '{num: 16, dwell: 1, loop: 1'b0, stop_at: 0, exp_writes: 16, exp_gap: 4};
        rows[4] = '{num: 2,  dwell: 0, loop: 1'b0, stop_at: 0, exp_writes: 2,  exp_gap: 4};
        rows[5] = '{num: 4,  dwell: 2, loop: 1'b1, stop_at: 6, exp_writes: 6,  exp_gap: 5};

        tbl[0] = 32'h0123_4567;
        tbl[1] = 32'h89AB_CDEF;
        tbl[2] = 32'h5555_AAAA;
        for (int i = 3; i < 16; i++) tbl[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;

        i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_loop = 1'b0;
        i_num_entries = '0; i_dwell = '0; i_tbl_we = 1'b0; i_tbl_addr = '0;
        i_tbl_data = '0; i_wb_stall = 1'b0;
        repeat (3) tick;
        check("reset outputs", {o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_hop_strobe, o_err,
                                o_hop_index, 2'(o_wb_addr)}, 32'd0);
        check("reset data", o_wb_data, 32'd0);
        i_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            i_tbl_we = 1'b1; i_tbl_addr = 4'(i); i_tbl_data = tbl[i];
            tick;
        end
        i_tbl_we = 1'b0;
        mon_en = 1'b1;

        for (int ri = 0; ri < 6; ri++) run_row(ri, rows[ri]);

        // Stall held for the first four strobe cycles.
        i_num_entries = 5'd1; i_dwell = 24'd3; i_loop = 1'b0;
        i_wb_stall = 1'b1; i_start = 1'b1;
        stb_n = 0; acks = 0; n = 0; unstable = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick;
            i_start = 1'b0;
            if (o_wb_stb) begin
                stb_n++;
                if (o_wb_data !== tbl[0] || o_wb_addr !== 2'd0 || !o_wb_we) unstable = 1'b1;
                if (stb_n == 5) i_wb_stall = 1'b0;
            end
            if (i_wb_ack) acks++;
            if (o_hop_strobe) n++;
            if (!o_busy) break;
        end
        i_wb_stall = 1'b0;
        check("stall stb cycles", 32'(stb_n), 32'd5);
        check("stall bus stable", 32'(unstable), 32'd0);
        check("stall ack count", 32'(acks), 32'd1);
        check("stall strobe count", 32'(n), 32'd1);
        check("stall idle at end", 32'(o_busy), 32'd0);
        repeat (3) tick;

        // Slave never acks: abort after the timeout with the error flag set.
        ack_en = 1'b0;
        i_num_entries = 5'd2; i_dwell = 24'd1; i_start = 1'b1;
        wait_n = 0; n = 0;
        for (int c = 0; c < 100; c++) begin
            tick;
            i_start = 1'b0;
            if (o_wb_cyc && !o_wb_stb) wait_n++;
            if (o_hop_strobe) n++;
            if (!o_busy) break;
        end
        check("timeout wait cycles", 32'(wait_n), 32'd15);
        check("timeout err", 32'(o_err), 32'd1);
        check("timeout cyc/busy", {o_wb_cyc, o_busy}, 32'd0);
        check("timeout strobes", 32'(n), 32'd0);
        i_num_entries = 5'd0; i_start = 1'b1;
        tick; i_start = 1'b0; tick;
        check("num=0 start keeps err", {o_err, o_busy}, 32'h2);
        ack_en = 1'b1;
        i_num_entries = 5'd1; i_start = 1'b1;
        tick; i_start = 1'b0;
        check("restart clears err", {o_err, o_busy}, 32'h1);
        for (int c = 0; c < 50 && o_busy; c++) tick;
        check("restart completes", 32'(o_busy), 32'd0);
        repeat (2) tick;

        // Reset while waiting for ack.
        ack_en = 1'b0;
        i_num_entries = 5'd1; i_start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick;
            i_start = 1'b0;
            if (o_wb_cyc && !o_wb_stb) break;
        end
        check("reached wait_ack", {o_wb_cyc, o_wb_stb}, 32'h2);
        i_reset = 1'b1;
        tick;
        check("reset in wait_ack", {o_wb_cyc, o_wb_stb, o_busy, o_hop_strobe}, 32'd0);
        i_reset = 1'b0;
        ack_en = 1'b1;
        i_num_entries = 5'd0; i_start = 1'b1;
        active = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            i_start = 1'b0;
            if (o_wb_cyc || o_busy) active = 1'b1;
        end
        check("num=0 start no activity", 32'(active), 32'd0);
        i_num_entries = 5'd1; i_start = 1'b1; i_stop = 1'b1;
        active = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            i_start = 1'b0; i_stop = 1'b0;
            if (o_wb_cyc || o_busy) active = 1'b1;
        end
        check("start+stop stays idle", 32'(active), 32'd0);

        // Stop during a stalled write: finish the transaction, then idle with no dwell.
        i_num_entries = 5'd3; i_dwell = 24'd4; i_loop = 1'b1;
        i_wb_stall = 1'b1; i_start = 1'b1;
        stb_n = 0; n = 0; acks = 0; wait_n = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            i_start = 1'b0; i_stop = 1'b0;
            if (o_wb_stb) begin
                stb_n++;
                if (stb_n == 1) i_stop = 1'b1;
                if (stb_n == 3) i_wb_stall = 1'b0;
            end
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) acks++;
            if (o_hop_strobe) begin
                n++;
                check("stop-write idle at strobe", 32'(o_busy), 32'd0);
            end
            if (!o_busy && c > 2) break;
        end
        i_wb_stall = 1'b0;
        active = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (o_wb_cyc || o_busy) active = 1'b1;
        end
        check("stop-write writes", 32'(acks), 32'd1);
        check("stop-write strobes", 32'(n), 32'd1);
        check("stop-write no further bus", 32'(active), 32'd0);

        // Table write to the entry being loaded returns the old word.
        i_num_entries = 5'd1; i_dwell = 24'd1; i_loop = 1'b0; i_start = 1'b1;
        tick; i_start = 1'b0;
        i_tbl_we = 1'b1; i_tbl_addr = 4'd0; i_tbl_data = 32'hDEAD_BEEF;
        tick; i_tbl_we = 1'b0;
        check("collision stb", 32'(o_wb_stb), 32'd1);
        check("collision old data", o_wb_data, tbl[0]);
        for (int c = 0; c < 50 && o_busy; c++) tick;
        tbl[0] = 32'hDEAD_BEEF;
        i_start = 1'b1;
        tick; i_start = 1'b0; tick;
        check("collision new data next run", o_wb_data, tbl[0]);
        for (int c = 0; c < 50 && o_busy; c++) tick;

        check("bus invariants violations", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
